// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared mode type, reset divisor
// and select-width helper for clk_div_bank.
package clk_div_pkg;

    typedef enum logic {
        SQUARE = 1'b0,
        PULSE  = 1'b1
    } div_mode_e;

    localparam int DEFAULT_DIV = 800;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with a
// shadowed divisor/mode applied at period end.
module clk_div_channel #(
    parameter int WIDTH   = 10,
    parameter int RST_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_div,
    input  clk_div_pkg::div_mode_e wr_mode,
    output logic                   pending,
    output logic [WIDTH-1:0]       q,
    output logic                   lohi,
    output logic                   tick
);
    import clk_div_pkg::*;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(RST_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] div_q;
    div_mode_e        mode_q;
    logic [WIDTH-1:0] shd_div;
    div_mode_e        shd_mode;

    logic             off;
    logic             run;
    logic             term;
    logic             apply;
    logic             mode_chg;
    logic             lohi_run;

    logic [WIDTH-1:0] q_nx;
    logic [WIDTH-1:0] div_nx;
    div_mode_e        mode_nx;
    logic [WIDTH-1:0] shd_div_nx;
    div_mode_e        shd_mode_nx;
    logic             pend_nx;
    logic             lohi_nx;

    assign off      = (div_q == '0);
    assign run      = ~enable_n & ~off;
    assign term     = run & (q == div_q - ONE);
    assign mode_chg = (shd_mode != mode_q);
    assign tick     = term & ~reset;

    // A stopped or disabled channel has no period
    // to finish, so the shadow may land at once.
    assign apply = pending & (term | off | enable_n);

    // lohi as it evolves under the current divisor/mode
    always_comb begin
        lohi_run = 1'b0;
        unique case (1'b1)
            off:                          lohi_run = 1'b0;
            (~off && mode_q == SQUARE):   lohi_run = lohi ^ term;
            (~off && mode_q == PULSE):    lohi_run = term;
            default:                      lohi_run = 1'b0;
        endcase
    end

    // next counter, active config, shadow and lohi
    always_comb begin
        q_nx        = q;
        div_nx      = div_q;
        mode_nx     = mode_q;
        shd_div_nx  = shd_div;
        shd_mode_nx = shd_mode;
        pend_nx     = pending;
        lohi_nx     = lohi_run;

        if (apply) begin
            q_nx    = '0;
            div_nx  = shd_div;
            mode_nx = shd_mode;
            pend_nx = 1'b0;
            if (mode_chg || shd_div == '0) begin
                lohi_nx = 1'b0;
            end
        end else if (term) begin
            q_nx = '0;
        end else if (run) begin
            q_nx = q + ONE;
        end

        // apply needs pending=1, a write needs
        // pending=0, so the two never collide
        if (wr_en && !pending) begin
            pend_nx     = 1'b1;
            shd_div_nx  = wr_div;
            shd_mode_nx = wr_mode;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '0;
            div_q    <= DIV_RST;
            mode_q   <= SQUARE;
            shd_div  <= DIV_RST;
            shd_mode <= SQUARE;
            pending  <= 1'b0;
            lohi     <= 1'b0;
        end else begin
            q        <= q_nx;
            div_q    <= div_nx;
            mode_q   <= mode_nx;
            shd_div  <= shd_div_nx;
            shd_mode <= shd_mode_nx;
            pending  <= pend_nx;
            lohi     <= lohi_nx;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: CHANNELS independent dividers
// behind one valid/ready config port.
module clk_div_bank #(
    parameter int  WIDTH       = 10,
    parameter int  CHANNELS    = 2,
    parameter int  DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
    localparam int CH_W        = clk_div_pkg::sel_width(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable_n,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [CH_W-1:0]                cfg_ch,
    input  logic [WIDTH-1:0]               cfg_div,
    input  logic                           cfg_mode,
    output logic [CHANNELS-1:0][WIDTH-1:0] q,
    output logic [CHANNELS-1:0]            lohi,
    output logic [CHANNELS-1:0]            tick
);
    import clk_div_pkg::*;

    logic [CHANNELS-1:0] sel;
    logic [CHANNELS-1:0] pend;
    logic                cfg_fire;
    div_mode_e           mode_in;

    assign mode_in = div_mode_e'(cfg_mode);

    // one-hot channel select; all zero when out of range
    always_comb begin
        sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel[i] = (cfg_ch == CH_W'(i));
        end
    end

    // out-of-range targets are always ready and dropped
    assign cfg_ready = ~|(sel & pend);
    assign cfg_fire  = cfg_valid & cfg_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clk_div_channel #(
            .WIDTH   (WIDTH),
            .RST_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .enable_n (enable_n),
            .wr_en    (cfg_fire & sel[i]),
            .wr_div   (cfg_div),
            .wr_mode  (mode_in),
            .pending  (pend[i]),
            .q        (q[i]),
            .lohi     (lohi[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: vector table, directed corner
// sequences and random stimulus vs a phase model.
module tb_clk_div_bank;

    localparam int NCH = 3;
    localparam int W   = 10;
    localparam int DEF = 800;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable_n;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [1:0]              cfg_ch;
    logic [W-1:0]            cfg_div;
    logic                    cfg_mode;
    logic [NCH-1:0][W-1:0]   q;
    logic [NCH-1:0]          lohi;
    logic [NCH-1:0]          tick;

    int n_chk  = 0;
    int n_fail = 0;

    clk_div_bank #(
        .WIDTH       (W),
        .CHANNELS    (NCH),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable_n  (enable_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .q         (q),
        .lohi      (lohi),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Channel position = enabled cycles since last
    // apply (ph). q = ph mod D; square output =
    // base xor parity(ph div D).
    int m_div  [NCH];
    int m_ph   [NCH];
    int m_sdiv [NCH];
    bit m_mode [NCH];
    bit m_smode[NCH];
    bit m_pend [NCH];
    bit m_lohi [NCH];
    bit m_base [NCH];

    function automatic int m_q(int c);
        if (m_div[c] == 0) return 0;
        return m_ph[c] % m_div[c];
    endfunction

    function automatic bit m_tick(int c);
        return !reset && !enable_n && m_div[c] != 0
               && m_q(c) == m_div[c] - 1;
    endfunction

    function automatic bit m_ready();
        if (int'(cfg_ch) >= NCH) return 1'b1;
        return !m_pend[int'(cfg_ch)];
    endfunction

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit t;
            bit run;
            bit acc;
            bit app;
            bit ln;
            int phn;
            if (reset) begin
                m_div[c]  = DEF;
                m_mode[c] = 1'b0;
                m_ph[c]   = 0;
                m_pend[c] = 1'b0;
                m_lohi[c] = 1'b0;
                m_base[c] = 1'b0;
            end else begin
                t   = m_tick(c);
                run = !enable_n && m_div[c] != 0;
                phn = m_ph[c] + (run ? 1 : 0);
                if (m_div[c] == 0)
                    ln = 1'b0;
                else if (m_mode[c] == 1'b0)
                    ln = m_base[c] ^ (((phn / m_div[c]) % 2) == 1);
                else
                    ln = t;
                acc = cfg_valid && int'(cfg_ch) == c && !m_pend[c];
                app = m_pend[c] && (t || m_div[c] == 0 || enable_n);
                if (app) begin
                    if (m_smode[c] != m_mode[c] || m_sdiv[c] == 0)
                        ln = 1'b0;
                    m_div[c]  = m_sdiv[c];
                    m_mode[c] = m_smode[c];
                    m_ph[c]   = 0;
                    m_base[c] = ln;
                    m_pend[c] = 1'b0;
                end else begin
                    m_ph[c] = phn;
                end
                m_lohi[c] = ln;
                if (acc) begin
                    m_pend[c]  = 1'b1;
                    m_sdiv[c]  = int'(cfg_div);
                    m_smode[c] = cfg_mode;
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic set_in(bit r, bit en, bit v, int ch,
                          int dv, bit md);
        reset     = r;
        enable_n  = en;
        cfg_valid = v;
        cfg_ch    = 2'(ch);
        cfg_div   = W'(dv);
        cfg_mode  = md;
        #1;
    endtask

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        logic [31:0] el;
        logic [31:0] et;
        el = '0;
        et = '0;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("model q%0d", c), 32'(q[c]), m_q(c));
            el[c] = m_lohi[c];
            et[c] = m_tick(c);
        end
        chk("model lohi", 32'(lohi), el);
        chk("model tick", 32'(tick), et);
        chk("model cfg_ready", 32'(cfg_ready), 32'(m_ready()));
    endtask

    task automatic cyc();
        check_model();
        clk_edge();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         chk;
        bit         rst;
        bit         en_n;
        bit         v;
        int         ch;
        int         dv;
        bit         md;
        int         q0;
        int         q1;
        logic [1:0] lo;
        logic [1:0] tk;
        bit         rdy;
    } vec_t;

    vec_t tv[$];

    function automatic void add(bit c, bit r, bit e, bit v,
        int ch, int dv, bit md, int q0, int q1,
        logic [1:0] lo, logic [1:0] tk, bit rdy);
        vec_t x;
        x.chk = c;  x.rst = r;  x.en_n = e; x.v = v;
        x.ch = ch;  x.dv = dv;  x.md = md;
        x.q0 = q0;  x.q1 = q1;  x.lo = lo; x.tk = tk;
        x.rdy = rdy;
        tv.push_back(x);
    endfunction

    initial begin
        int rise;
        int fall;
        int q799;
        int q800;
        int lowcnt;
        int nt;
        int nl;
        int bad;
        bit prev_t;
        int n;

        // chk rst en v ch div md | q0 q1 lohi tick rdy
        add(0, 1, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1);
        add(1, 0, 1, 1, 0, 3, 0,  0, 0, 2'b00, 2'b00, 1);
        add(1, 0, 1, 1, 1, 2, 1,  0, 0, 2'b00, 2'b00, 1);
        add(1, 0, 0, 1, 1, 7, 0,  0, 0, 2'b00, 2'b00, 0);
        add(1, 0, 1, 0, 0, 0, 0,  1, 1, 2'b00, 2'b00, 1);
        add(1, 0, 0, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 1);
        add(1, 0, 0, 0, 0, 0, 0,  2, 1, 2'b00, 2'b11, 1);
        add(1, 0, 0, 0, 0, 0, 0,  0, 0, 2'b11, 2'b00, 1);
        add(1, 0, 0, 0, 0, 0, 0,  1, 1, 2'b01, 2'b10, 1);
        add(1, 0, 0, 1, 0, 1, 0,  2, 0, 2'b11, 2'b01, 1);
        add(1, 0, 0, 0, 0, 0, 0,  0, 1, 2'b00, 2'b10, 0);
        add(1, 0, 0, 0, 0, 0, 0,  1, 0, 2'b10, 2'b00, 0);
        add(1, 0, 0, 0, 0, 0, 0,  2, 1, 2'b00, 2'b11, 0);
        add(1, 0, 0, 0, 0, 0, 0,  0, 0, 2'b11, 2'b01, 1);
        add(1, 0, 0, 0, 0, 0, 0,  0, 1, 2'b00, 2'b11, 1);
        add(1, 0, 1, 1, 0, 0, 0,  0, 0, 2'b11, 2'b00, 1);
        add(1, 0, 0, 0, 0, 0, 0,  0, 0, 2'b01, 2'b01, 0);
        add(1, 0, 0, 0, 0, 0, 0,  0, 1, 2'b00, 2'b10, 1);
        add(1, 0, 0, 0, 0, 0, 0,  0, 0, 2'b10, 2'b00, 1);
        add(1, 1, 0, 1, 0, 5, 0,  0, 1, 2'b00, 2'b00, 1);
        add(1, 0, 1, 1, 3, 2, 0,  0, 0, 2'b00, 2'b00, 1);
        add(1, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1);

        foreach (tv[i]) begin
            set_in(tv[i].rst, tv[i].en_n, tv[i].v, tv[i].ch,
                   tv[i].dv, tv[i].md);
            if (tv[i].chk) begin
                chk($sformatf("tv%0d q0", i), 32'(q[0]), tv[i].q0);
                chk($sformatf("tv%0d q1", i), 32'(q[1]), tv[i].q1);
                chk($sformatf("tv%0d lohi", i), 32'(lohi[1:0]),
                    32'(tv[i].lo));
                chk($sformatf("tv%0d tick", i), 32'(tick[1:0]),
                    32'(tv[i].tk));
                chk($sformatf("tv%0d ready", i), 32'(cfg_ready),
                    32'(tv[i].rdy));
            end
            clk_edge();
        end

        // defaults: 2-cycle reset then 1600 enabled cycles
        set_in(1, 0, 0, 0, 0, 0);
        clk_edge();
        clk_edge();
        set_in(0, 0, 0, 0, 0, 0);
        rise = -1;
        fall = -1;
        q799 = -1;
        q800 = -1;
        for (int k = 1; k <= 1600; k++) begin
            cyc();
            if (lohi[0] && rise < 0) rise = k;
            if (!lohi[0] && rise >= 0 && fall < 0) fall = k;
            if (k == 799) q799 = int'(q[0]);
            if (k == 800) q800 = int'(q[0]);
        end
        chk("default lohi rise", rise, 800);
        chk("default lohi fall", fall, 1600);
        chk("default q before wrap", q799, 799);
        chk("default q after wrap", q800, 0);

        // mid-count write to ch1: waits for the wrap
        for (int k = 0; k < 100; k++) cyc();
        chk("pend q1 before write", 32'(q[1]), 100);
        set_in(0, 0, 1, 1, 5, 1);
        chk("pend ready at write", 32'(cfg_ready), 1);
        cyc();
        set_in(0, 0, 0, 1, 0, 0);
        lowcnt = 0;
        for (int k = 0; k < 1000; k++) begin
            if (cfg_ready === 1'b1) break;
            lowcnt++;
            cyc();
        end
        chk("pend ready low cycles", lowcnt, DEF - 101);
        chk("pend q1 after apply", 32'(q[1]), 0);
        nt = 0;
        nl = 0;
        bad = 0;
        prev_t = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (tick[1]) nt++;
            if (lohi[1]) nl++;
            if (lohi[1] !== prev_t) bad++;
            prev_t = tick[1];
            cyc();
        end
        chk("pulse tick count", nt, 4);
        chk("pulse lohi count", nl, 3);
        chk("pulse lohi follows tick", bad, 0);

        // enable_n pause at q=3, D=5
        for (int k = 0; k < 10; k++) begin
            if (q[1] == 3) break;
            cyc();
        end
        chk("pause q1 start", 32'(q[1]), 3);
        set_in(0, 1, 0, 1, 0, 0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (q[1] != 3 || tick[1]) bad++;
            cyc();
        end
        chk("pause hold", bad, 0);
        set_in(0, 0, 0, 1, 0, 0);
        cyc();
        chk("resume q1", 32'(q[1]), 4);
        chk("resume tick1", 32'(tick[1]), 1);

        // reset with a pending shadow and lohi high
        for (int k = 0; k < 3000; k++) begin
            if (lohi[0] === 1'b1) break;
            cyc();
        end
        chk("rst lohi0 high", 32'(lohi[0]), 1);
        set_in(0, 0, 1, 0, 3, 1);
        chk("rst write ready", 32'(cfg_ready), 1);
        cyc();
        set_in(0, 0, 0, 0, 0, 0);
        chk("rst pending seen", 32'(cfg_ready), 0);
        set_in(1, 0, 0, 0, 0, 0);
        cyc();
        set_in(0, 0, 0, 0, 0, 0);
        chk("rst q all", 32'(q), 0);
        chk("rst lohi", 32'(lohi), 0);
        chk("rst tick", 32'(tick), 0);
        chk("rst ready", 32'(cfg_ready), 1);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            if (tick[0]) break;
            n++;
            cyc();
        end
        chk("rst default period", n, DEF - 1);

        // random traffic against the model
        set_in(1, 0, 0, 0, 0, 0);
        clk_edge();
        for (int k = 0; k < 3000; k++) begin
            int dv;
            dv = ($urandom_range(0, 15) == 0)
                 ? int'($urandom_range(0, 1023))
                 : int'($urandom_range(0, 7));
            set_in($urandom_range(0, 299) == 0,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0,
                   int'($urandom_range(0, 3)),
                   dv,
                   1'($urandom_range(0, 1)));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_chk, n_fail);
        $finish;
    end

endmodule
